// File: rtl/re_lod32_pkg.sv
// Shared widths, stage payload types and the S2 merge helper for re_lod32.
package re_lod32_pkg;

    localparam int unsigned NUM_W  = 32;
    localparam int unsigned K_W    = 5;
    localparam int unsigned HALF_W = NUM_W / 2;
    localparam int unsigned IDX_W  = K_W - 1;

    // S1 payload: operand plus per-half leading-one results
    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic             hi_any;
        logic [IDX_W-1:0] hi_idx;
        logic             lo_any;
        logic [IDX_W-1:0] lo_idx;
    } s1_t;

    // S2 payload: what shifter32 consumes
    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic [K_W-1:0]   k;
        logic             zero;
    } s2_t;

    // Combine half results; lo_idx is 0 when the low half is empty, so k=0 on zero
    function automatic s2_t lod_merge(s1_t s);
        s2_t r;
        r.num  = s.num;
        r.k    = s.hi_any ? {1'b1, s.hi_idx} : {1'b0, s.lo_idx};
        r.zero = !s.hi_any && !s.lo_any;
        return r;
    endfunction

endpackage

// File: rtl/re_lod32_lod16.sv
// re_lod16: combinational 16-bit priority encoder, index of highest set bit.
module re_lod16
    import re_lod32_pkg::*;
(
    input  logic [HALF_W-1:0] v_i,
    output logic              any_c_o,
    output logic [IDX_W-1:0]  idx_c_o
);

    // Later (higher) set bits overwrite earlier ones; idx stays 0 when empty
    always_comb begin
        any_c_o = |v_i;
        idx_c_o = '0;
        for (int i = 0; i < int'(HALF_W); i++) begin
            if (v_i[i]) idx_c_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/re_lod32.sv
// re_lod32: two-stage leading-one detector feeding shifter32.
// Optional feature: RE_LOD_SKID_EN adds a 1-entry output skid buffer and
// registers in_ready so out_ready has no combinational path to it.
module re_lod32
    import re_lod32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] in_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] out_num,
    output logic [K_W-1:0]   out_k,
    output logic             out_zero
);

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic hi_any, lo_any;
    logic [IDX_W-1:0] hi_idx, lo_idx;
    logic s1_load, s2_load, s2_leave, s2_can_load;

    re_lod16 u_lod_hi (.v_i(in_num[NUM_W-1:HALF_W]), .any_c_o(hi_any), .idx_c_o(hi_idx));
    re_lod16 u_lod_lo (.v_i(in_num[HALF_W-1:0]),     .any_c_o(lo_any), .idx_c_o(lo_idx));

`ifdef RE_LOD_SKID_EN
    s2_t  skid_q, skid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;

    // S2 always empties while the skid is free: to the output or into the skid
    always_comb begin
        s2_leave     = s2_valid_q && !skid_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (out_ready) skid_valid_d = 1'b0;
        end else if (s2_valid_q && !out_ready) begin
            skid_valid_d = 1'b1;
            skid_d       = s2_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = skid_valid_q || s2_valid_q;
    assign out_num   = skid_valid_q ? skid_q.num  : s2_q.num;
    assign out_k     = skid_valid_q ? skid_q.k    : s2_q.k;
    assign out_zero  = skid_valid_q ? skid_q.zero : s2_q.zero;

    // Next-cycle acceptance depends only on next-cycle occupancy
    assign in_ready_d = !skid_valid_d || !s1_valid_d || !s2_valid_d;

    // Skid entry and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign s2_leave  = s2_valid_q && out_ready;
    assign in_ready  = !s1_valid_q || s2_can_load;
    assign out_valid = s2_valid_q;
    assign out_num   = s2_q.num;
    assign out_k     = s2_q.k;
    assign out_zero  = s2_q.zero;
`endif

    assign s2_can_load = !s2_valid_q || s2_leave;
    assign s2_load     = s1_valid_q && s2_can_load;
    assign s1_load     = in_valid && in_ready;

    // Stage advance: load when empty or when current contents leave
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_d.num    = in_num;
            s1_d.hi_any = hi_any;
            s1_d.hi_idx = hi_idx;
            s1_d.lo_any = lo_any;
            s1_d.lo_idx = lo_idx;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_d       = lod_merge(s1_q);
        end else if (s2_leave) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

endmodule

// File: tb/tb_re_lod32.sv
// Self-checking bench for re_lod32: directed cases plus random stream vs. scoreboard.
module tb_re_lod32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num;
    logic [4:0]  out_k;
    logic        out_zero;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;

    logic [31:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_num;
    logic [4:0]  hold_k;
    logic        hold_zero;

    re_lod32 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_num   (in_num),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_num  (out_num),
        .out_k    (out_k),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: position of the most significant one, 0 for a zero operand
    function automatic int ref_k(input logic [31:0] n);
        int k = 0;
        logic [31:0] v = n;
        while (v > 32'd1) begin
            v = v >> 1;
            k++;
        end
        return k;
    endfunction

    // One cycle: drive at negedge, settle, score handshakes that the next posedge commits
    task automatic step(input logic iv, input logic [31:0] n, input logic ordy);
        logic [31:0] e;
        @(negedge clk);
        in_valid  = iv;
        in_num    = n;
        out_ready = ordy;
        #1;
        if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_num",   out_num, hold_num);
            chk("hold_k",     32'(out_k), 32'(hold_k));
            chk("hold_zero",  32'(out_zero), 32'(hold_zero));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_num",  out_num, e);
                chk("out_k",    32'(out_k), 32'(ref_k(e)));
                chk("out_zero", 32'(out_zero), 32'(e == 32'd0));
            end
        end
        hold_pending = out_valid && !out_ready;
        hold_num     = out_num;
        hold_k       = out_k;
        hold_zero    = out_zero;
        if (in_valid && in_ready) begin
            exp_q.push_back(n);
            n_acc++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            step(1'b0, 32'd0, 1'b1);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] b2b[3];
        logic [4:0]  b2b_k[3];
        logic [31:0] r;
        int          cyc;
        logic        ir_a;

        rst = 1'b1; in_valid = 1'b0; in_num = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_num",   out_num, 32'd0);
        chk("rst_out_k",     32'(out_k), 32'd0);
        chk("rst_out_zero",  32'(out_zero), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency and MSB at bit 31
        step(1'b1, 32'h8000_0000, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("msb31_k",      32'(out_k), 32'd31);
        chk("msb31_zero",   32'(out_zero), 32'd0);

        // Lowest bit and zero operand
        step(1'b1, 32'h0000_0001, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("one_k",    32'(out_k), 32'd0);
        chk("one_zero", 32'(out_zero), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        chk("zero_k",    32'(out_k), 32'd0);
        chk("zero_zero", 32'(out_zero), 32'd1);
        drain();

        // Back-to-back operands, continuous output
        b2b[0] = 32'h0001_0000; b2b_k[0] = 5'd16;
        b2b[1] = 32'h0000_8000; b2b_k[1] = 5'd15;
        b2b[2] = 32'h00FF_FFFF; b2b_k[2] = 5'd23;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, b2b[i], 1'b1);
            else       step(1'b0, 32'd0, 1'b1);
            if (i < 3) chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_k",     32'(out_k), 32'(b2b_k[i-2]));
            end
        end
        drain();

        // Five-cycle downstream stall while streaming
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0000_0100 << i, 1'b0);
            if (i == 4) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_valid",    32'(out_valid), 32'd1);
            end
        end
`ifdef RE_LOD_SKID_EN
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 ir_a = in_ready;
        out_ready = 1'b1;
        #1 chk("skid_no_comb_path", 32'(in_ready), 32'(ir_a));
        out_ready = 1'b0;
        #1;
`else
        ir_a = 1'b0;
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0700_0000 >> i, 1'b1);
        drain();

        // Reset with two operands in flight
        step(1'b1, 32'h1234_5678, 1'b0);
        step(1'b1, 32'h0000_00F0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 1'b1);
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Random stream against the scoreboard
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            r = $urandom;
            r = r >> $urandom_range(0, 32);
            step(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 9) < 7));
            cyc++;
        end
        chk("random_ops_done", 32'(n_acc >= 10000), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
